// File: rtl/ddr_package.sv
// Shared types and default timing for the DDR column-command path.
// Holds the request encoding, scheduler states and the turnaround rule.
package ddr_package;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } rw_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RCD,
    S_WAIT_GAP,
    S_ISSUE
  } cas_sched_state_t;

  typedef struct packed {
    rw_t        rw;
    logic [3:0] bank;
  } cas_cmd_t;

  localparam int DEF_T_CCD = 4;
  localparam int DEF_T_RTW = 10;
  localparam int DEF_T_WTR = 15;

  // Minimum cycles between the previous accepted CAS and the head, by type pair.
  function automatic int required_gap(rw_t last, rw_t head, int t_ccd, int t_rtw, int t_wtr);
    if (last == NONE)      return 0;
    else if (last == head) return t_ccd;
    else if (last == READ) return t_rtw;
    else                   return t_wtr;
  endfunction

endpackage

// File: rtl/cas_pending_fifo.sv
// Pending CAS queue; every stored entry counts its ACT-to-CAS delay down to 0.
// Head fields are combinational from state; a push while full must be gated by the caller.
module cas_pending_fifo
  import ddr_package::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 6
) (
  input  logic                   clock_t,
  input  logic                   reset,
  input  logic                   push,
  input  cas_cmd_t               push_cmd,
  input  logic [CNT_W-1:0]       push_rcd,
  input  logic                   pop,
  output cas_cmd_t               head_cmd,
  output logic                   head_rcd_ready,
  output logic                   next_rcd_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  cas_cmd_t         cmd_q [DEPTH];
  cas_cmd_t         cmd_d [DEPTH];
  logic [CNT_W-1:0] rcd_q [DEPTH];
  logic [CNT_W-1:0] rcd_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [PTR_W:0]   count_q, count_d;

  assign rd_nxt = rd_ptr_q + 1'b1;

  always_comb begin
    cmd_d    = cmd_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      rcd_d[i] = (rcd_q[i] != '0) ? rcd_q[i] - 1'b1 : '0;
    end
    if (push) begin
      cmd_d[wr_ptr_q] = push_cmd;
      rcd_d[wr_ptr_q] = push_rcd;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_nxt;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: only slots inside the count window are ever read.
  always_ff @(posedge clock_t) begin
    cmd_q <= cmd_d;
    rcd_q <= rcd_d;
  end

  assign head_cmd       = cmd_q[rd_ptr_q];
  assign head_rcd_ready = (rcd_q[rd_ptr_q] == '0);
  assign next_rcd_ready = (rcd_q[rd_nxt] <= CNT_W'(1));
  assign count          = count_q;
  assign full           = (count_q == FULL_CNT);
  assign empty          = (count_q == '0);

endmodule

// File: rtl/cas_scheduler.sv
// Releases queued CAS commands once ACT-to-CAS delay and CAS/turnaround gaps are met.
// cas_valid/cas_rw/cas_bank are registered and hold until cas_accept; pushes while full drop.
module cas_scheduler
  import ddr_package::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 6,
  parameter int T_CCD = DEF_T_CCD,
  parameter int T_RTW = DEF_T_RTW,
  parameter int T_WTR = DEF_T_WTR
) (
  input  logic             clock_t,
  input  logic             reset,
  input  logic             act_rdy,
  input  logic [1:0]       act_rw,
  input  logic [3:0]       act_bank,
  input  logic [CNT_W-1:0] cas_delay,
  output logic             cas_valid,
  output logic [1:0]       cas_rw,
  output logic [3:0]       cas_bank,
  input  logic             cas_accept,
  output logic             q_full,
  output logic             cas_idle,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] GAP_MAX = '1;
  localparam int               CW      = $clog2(DEPTH) + 1;

  cas_sched_state_t state_q, state_d;
  rw_t              last_rw_q, last_rw_d, cas_rw_q, cas_rw_d;
  logic [CNT_W-1:0] gap_q, gap_d, gap_nxt, push_rcd;
  logic [3:0]       cas_bank_q, cas_bank_d;
  logic             cas_valid_q, cas_valid_d, overflow_q, overflow_d;

  cas_cmd_t         push_cmd, head_cmd;
  logic             head_rcd_ready, next_rcd_ready, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             push_req, push, pop, gap_ready, empty_after_pop, ready_after_pop;

  assign push_req        = act_rdy && (act_rw == READ || act_rw == WRITE);
  assign pop             = cas_valid_q && cas_accept;
  assign push            = push_req && (!fifo_full || pop);
  assign push_cmd        = '{rw: rw_t'(act_rw), bank: act_bank};
  assign push_rcd        = (cas_delay == '0) ? '0 : cas_delay - 1'b1;
  assign empty_after_pop = (fifo_count == CW'(1)) && !push;
  assign ready_after_pop = (fifo_count > CW'(1)) ? next_rcd_ready : (cas_delay <= CNT_W'(1));

  // Readiness looks at the count the head would see in the cycle cas_valid rises.
  assign gap_nxt   = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
  assign gap_ready = int'(gap_nxt) >= required_gap(last_rw_q, head_cmd.rw, T_CCD, T_RTW, T_WTR);

  cas_pending_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clock_t        (clock_t),
    .reset          (reset),
    .push           (push),
    .push_cmd       (push_cmd),
    .push_rcd       (push_rcd),
    .pop            (pop),
    .head_cmd       (head_cmd),
    .head_rcd_ready (head_rcd_ready),
    .next_rcd_ready (next_rcd_ready),
    .count          (fifo_count),
    .full           (fifo_full),
    .empty          (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    last_rw_d   = last_rw_q;
    gap_d       = gap_nxt;
    cas_valid_d = cas_valid_q;
    cas_rw_d    = cas_rw_q;
    cas_bank_d  = cas_bank_q;
    overflow_d  = overflow_q || (push_req && fifo_full && !pop);
    case (state_q)
      S_IDLE: begin
        if (push) state_d = S_WAIT_RCD;
      end
      S_WAIT_RCD, S_WAIT_GAP: begin
        if (head_rcd_ready && gap_ready) begin
          state_d     = S_ISSUE;
          cas_valid_d = 1'b1;
          cas_rw_d    = head_cmd.rw;
          cas_bank_d  = head_cmd.bank;
        end else if (head_rcd_ready) begin
          state_d = S_WAIT_GAP;
        end
      end
      S_ISSUE: begin
        if (pop) begin
          last_rw_d   = cas_rw_q;
          gap_d       = CNT_W'(1);
          cas_valid_d = 1'b0;
          cas_rw_d    = NONE;
          cas_bank_d  = '0;
          if (empty_after_pop)      state_d = S_IDLE;
          else if (ready_after_pop) state_d = S_WAIT_GAP;
          else                      state_d = S_WAIT_RCD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_rw_q   <= NONE;
      gap_q       <= GAP_MAX;
      cas_valid_q <= 1'b0;
      cas_rw_q    <= NONE;
      cas_bank_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_rw_q   <= last_rw_d;
      gap_q       <= gap_d;
      cas_valid_q <= cas_valid_d;
      cas_rw_q    <= cas_rw_d;
      cas_bank_q  <= cas_bank_d;
      overflow_q  <= overflow_d;
    end
  end

  assign cas_valid = cas_valid_q;
  assign cas_rw    = cas_rw_q;
  assign cas_bank  = cas_bank_q;
  assign q_full    = fifo_full;
  assign cas_idle  = fifo_empty && (state_q == S_IDLE);
  assign overflow  = overflow_q;

endmodule
